x_dl_edge_encoder: RTL and testbench

X_DL_EDGE_ENCODER -- requirements
Module: x_dl_edge_encoder

---
 rtl/x_dl_pkg.sv | 36 +++
 rtl/x_dl_uart_tx.sv | 77 +++++++
 rtl/x_dl_edge_encoder.sv | 152 +++++++++++++++
 tb/tb_x_dl_edge_encoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/x_dl_pkg.sv
// -----------------------------------------------------------------------------
// x_dl_pkg
// Shared types and constants for the delay-line edge encoder.
//   enc_state_t   : encoder sequencing state (collect capture bits / send report)
//   NO_EDGE_IDX   : edge index reported when a capture holds no transition
//   REPORT_BYTES  : number of bytes in one UART report
//   report_byte() : selects one report byte from edge index and transition count
// -----------------------------------------------------------------------------
package x_dl_pkg;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_SEND    = 1'b1
   } enc_state_t;

   localparam logic [15:0] NO_EDGE_IDX  = 16'hFFFF;
   localparam logic [2:0]  REPORT_BYTES = 3'd4;

   // Report order: edge_idx lo, edge_idx hi, trans_cnt lo, trans_cnt hi.
   function automatic logic [7:0] report_byte(
      input logic [1:0]  idx,
      input logic [15:0] edge_idx,
      input logic [15:0] trans_cnt
   );
      logic [7:0] v;
      v = 8'h00;
      case (idx)
         2'd0: v = edge_idx[7:0];
         2'd1: v = edge_idx[15:8];
         2'd2: v = trans_cnt[7:0];
         2'd3: v = trans_cnt[15:8];
      endcase
      return v;
   endfunction

endpackage

// File: rtl/x_dl_uart_tx.sv
// -----------------------------------------------------------------------------
// x_uart_tx
// 8N1 UART byte serialiser. A byte is accepted when i_valid is high and o_busy
// is low; the start bit is driven from the following cycle. o_busy drops during
// the final cycle of the stop bit so the next byte can follow with no idle gap.
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset, line returns idle high
//   i_valid : byte strobe
//   i_data  : byte to send, LSB first
//   o_busy  : serialiser cannot take a byte this cycle
//   o_tx    : serial line, idle high
// -----------------------------------------------------------------------------
module x_uart_tx #(
   parameter int p_clk_hz = 12000000,
   parameter int p_baud   = 115200
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_busy,
   output logic       o_tx
);

   localparam int BIT_CYC = p_clk_hz / p_baud;
   localparam int TMR_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(BIT_CYC - 1);
   // slot 0 = start bit, 1..8 = data bits, 9 = stop bit
   localparam logic [3:0] STOP_SLOT = 4'd9;

   logic             r_busy;
   logic             r_tx;
   logic [8:0]       r_shift;
   logic [3:0]       r_slot;
   logic [TMR_W-1:0] r_timer;

   logic w_tc;
   logic w_last_cycle;
   logic w_load;

   assign w_tc         = (r_timer == '0);
   assign w_last_cycle = r_busy & w_tc & (r_slot == STOP_SLOT);
   assign w_load       = i_valid & (~r_busy | w_last_cycle);

   assign o_busy = r_busy & ~w_last_cycle;
   assign o_tx   = r_tx;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy  <= 1'b0;
         r_tx    <= 1'b1;
         r_shift <= '1;
         r_slot  <= 4'd0;
         r_timer <= '0;
      end else if (w_load) begin
         r_busy  <= 1'b1;
         r_tx    <= 1'b0;
         r_shift <= {1'b1, i_data};
         r_slot  <= 4'd0;
         r_timer <= TMR_RELOAD;
      end else if (r_busy) begin
         if (!w_tc) begin
            r_timer <= r_timer - TMR_W'(1);
         end else if (r_slot == STOP_SLOT) begin
            r_busy <= 1'b0;
            r_tx   <= 1'b1;
         end else begin
            // shift register backfills with ones so the stop bit falls out last
            r_tx    <= r_shift[0];
            r_shift <= {1'b1, r_shift[8:1]};
            r_slot  <= r_slot + 4'd1;
            r_timer <= TMR_RELOAD;
         end
      end
   end

endmodule

// File: rtl/x_dl_edge_encoder.sv
// -----------------------------------------------------------------------------
// x_dl_edge_encoder
// Collects one delay-line capture (tap 0 first), finds the tap index of the
// first transition and counts all transitions, then reports both as four UART
// bytes and returns to collecting.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_COLLECT | o_ready high, accepting capture bits
//   ST_SEND    | o_ready low, streaming the four report bytes over UART
//
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset, highest priority
//   i_valid      : capture bit valid
//   i_bit        : capture bit
//   i_last       : final bit of the capture
//   o_ready      : capture bits accepted this cycle
//   o_frame_done : one-cycle pulse after the last report stop bit
//   o_uart_tx    : 8N1 serial report, idle high
// -----------------------------------------------------------------------------
module x_dl_edge_encoder
   import x_dl_pkg::*;
#(
   parameter int p_dl_length = 4096,
   parameter int p_clk_hz    = 12000000,
   parameter int p_baud      = 115200
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_valid,
   input  logic i_bit,
   input  logic i_last,
   output logic o_ready,
   output logic o_frame_done,
   output logic o_uart_tx
);

   localparam logic [15:0] LAST_TAP = 16'(p_dl_length - 1);

   enc_state_t  r_state;
   enc_state_t  w_state_nxt;

   logic [15:0] r_tap_idx;
   logic [15:0] r_edge_idx;
   logic [15:0] r_trans_cnt;
   logic        r_prev_bit;
   logic        r_edge_found;
   logic        r_frame_done;
   logic [2:0]  r_byte_idx;

   logic        w_accept;
   logic        w_trans;
   logic        w_cap_end;
   logic        w_uart_valid;
   logic        w_uart_busy;
   logic        w_frame_end;
   logic [15:0] w_edge_rpt;
   logic [7:0]  w_uart_data;

   assign w_accept  = i_valid & (r_state == ST_COLLECT);
   // tap 0 has no predecessor in this capture, so it never counts as a transition
   assign w_trans   = w_accept & (r_tap_idx != 16'd0) & (i_bit != r_prev_bit);
   assign w_cap_end = w_accept & (i_last | (r_tap_idx == LAST_TAP));

   assign w_edge_rpt  = r_edge_found ? r_edge_idx : NO_EDGE_IDX;
   assign w_uart_data = report_byte(r_byte_idx[1:0], w_edge_rpt, r_trans_cnt);

   assign o_frame_done = r_frame_done;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_COLLECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      o_ready      = 1'b0;
      w_uart_valid = 1'b0;
      w_frame_end  = 1'b0;
      case (r_state)
         ST_COLLECT: begin
            o_ready = 1'b1;
            if (w_cap_end) begin
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!w_uart_busy) begin
               if (r_byte_idx < REPORT_BYTES) begin
                  w_uart_valid = 1'b1;
               end else begin
                  // serialiser idle with all bytes issued: last stop bit just ended
                  w_frame_end = 1'b1;
                  w_state_nxt = ST_COLLECT;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tap_idx    <= 16'd0;
         r_edge_idx   <= 16'd0;
         r_trans_cnt  <= 16'd0;
         r_prev_bit   <= 1'b0;
         r_edge_found <= 1'b0;
         r_frame_done <= 1'b0;
         r_byte_idx   <= 3'd0;
      end else begin
         r_frame_done <= w_frame_end;
         if (w_frame_end) begin
            r_tap_idx    <= 16'd0;
            r_edge_idx   <= 16'd0;
            r_trans_cnt  <= 16'd0;
            r_edge_found <= 1'b0;
            r_byte_idx   <= 3'd0;
         end else begin
            if (w_uart_valid) begin
               r_byte_idx <= r_byte_idx + 3'd1;
            end
            if (w_accept) begin
               r_tap_idx  <= r_tap_idx + 16'd1;
               r_prev_bit <= i_bit;
               if (w_trans) begin
                  r_trans_cnt <= r_trans_cnt + 16'd1;
                  if (!r_edge_found) begin
                     r_edge_found <= 1'b1;
                     r_edge_idx   <= r_tap_idx;
                  end
               end
            end
         end
      end
   end

   x_uart_tx #(
      .p_clk_hz (p_clk_hz),
      .p_baud   (p_baud)
   ) u_uart_tx (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (w_uart_valid),
      .i_data  (w_uart_data),
      .o_busy  (w_uart_busy),
      .o_tx    (o_uart_tx)
   );

endmodule

// File: tb/tb_x_dl_edge_encoder.sv
module tb_x_dl_edge_encoder;

   localparam int BIT_CYC = 104;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic i_rst;
   logic i_valid;
   logic i_bit;
   logic i_last;
   logic o_ready;
   logic o_frame_done;
   logic o_uart_tx;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   x_dl_edge_encoder dut (
      .i_clk        (clk_sys),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .i_bit        (i_bit),
      .i_last       (i_last),
      .o_ready      (o_ready),
      .o_frame_done (o_frame_done),
      .o_uart_tx    (o_uart_tx)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // capture patterns: 0 = zeros up to tap 99 then ones, 1 = all ones,
   // 2 = alternating starting with 0, 3 = five ones then zeros
   function automatic logic stim_bit(input int mode, input int i);
      logic b;
      b = 1'b0;
      case (mode)
         0: b = (i >= 100);
         1: b = 1'b1;
         2: b = i[0];
         3: b = (i < 5);
         default: b = 1'b0;
      endcase
      return b;
   endfunction

   // drives a capture, models the expected report and queues its bytes
   task automatic send_capture(input int mode, input int n, input bit use_last, input bit hold_valid);
      logic        b;
      logic        p;
      logic        found;
      logic [15:0] e;
      logic [15:0] t;
      p = 1'b0;
      found = 1'b0;
      e = 16'hFFFF;
      t = 16'd0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk_sys);
         if (i == 0) chk("ready_collect", o_ready, 1);
         b = stim_bit(mode, i);
         i_valid = 1'b1;
         i_bit   = b;
         i_last  = use_last && (i == n - 1);
         if (i > 0 && b != p) begin
            t = t + 16'd1;
            if (!found) begin
               found = 1'b1;
               e = i[15:0];
            end
         end
         p = b;
      end
      @(negedge clk_sys);
      i_last = 1'b0;
      if (!hold_valid) i_valid = 1'b0;
      chk("ready_low_after_capture", o_ready, 0);
      exp_q.push_back(e[7:0]);
      exp_q.push_back(e[15:8]);
      exp_q.push_back(t[7:0]);
      exp_q.push_back(t[15:8]);
   endtask

   // receives one four-byte report, checking every bit cycle against the queue
   task automatic rx_frame();
      int wait_n;
      int hit;
      logic       eb;
      logic [7:0] expb;
      logic [7:0] rxb;
      wait_n = 0;
      while (o_uart_tx === 1'b1 && wait_n < 20) begin
         @(negedge clk_sys);
         wait_n++;
      end
      chk("start_latency", wait_n, 1);
      for (int by = 0; by < 4; by++) begin
         expb = 8'h00;
         if (exp_q.size() > 0) expb = exp_q.pop_front();
         else chk("scoreboard_empty", exp_q.size(), 1);
         rxb = 8'h00;
         for (int b = 0; b < 10; b++) begin
            if (b == 0)      eb = 1'b0;
            else if (b == 9) eb = 1'b1;
            else             eb = expb[b-1];
            hit = 0;
            for (int k = 0; k < BIT_CYC; k++) begin
               if (by == 1 && b == 0 && k == 0) chk("ready_during_send", o_ready, 0);
               if (k == BIT_CYC / 2 && b >= 1 && b <= 8) rxb[b-1] = o_uart_tx;
               if (o_uart_tx === eb) hit++;
               @(negedge clk_sys);
            end
            chk("uart_bit_cycles", hit, BIT_CYC);
         end
         chk("rx_byte", rxb, expb);
      end
      chk("frame_done_pulse", o_frame_done, 1);
      chk("ready_after_frame", o_ready, 1);
      i_valid = 1'b0;
      @(negedge clk_sys);
      chk("frame_done_single", o_frame_done, 0);
   endtask

   initial begin
      int wait_n;
      int low_cnt;
      int done_cnt;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_bit   = 1'b0;
      i_last  = 1'b0;
      repeat (3) @(negedge clk_sys);
      chk("rst_tx", o_uart_tx, 1);
      chk("rst_ready", o_ready, 1);
      chk("rst_frame_done", o_frame_done, 0);
      i_rst = 1'b0;

      // edge at tap 100, single transition, full length
      send_capture(0, 4096, 1'b0, 1'b0);
      rx_frame();

      // all ones, no i_last: ends at tap 4095 with no edge
      send_capture(1, 4096, 1'b0, 1'b0);
      rx_frame();

      // alternating 16 bits, i_valid held high through the report
      send_capture(2, 16, 1'b1, 1'b1);
      rx_frame();

      // next capture must start from tap 0: edge at 5, one transition
      send_capture(3, 8, 1'b1, 1'b0);
      rx_frame();

      // i_last on tap 0
      send_capture(1, 1, 1'b1, 1'b0);
      rx_frame();

      // reset in the middle of the second report byte
      send_capture(2, 16, 1'b1, 1'b0);
      exp_q.delete();
      wait_n = 0;
      while (o_uart_tx === 1'b1 && wait_n < 20) begin
         @(negedge clk_sys);
         wait_n++;
      end
      chk("rst_test_start", o_uart_tx, 0);
      repeat (BIT_CYC * 10 + 300) @(negedge clk_sys);
      i_rst = 1'b1;
      @(negedge clk_sys);
      chk("midrst_tx", o_uart_tx, 1);
      chk("midrst_ready", o_ready, 1);
      chk("midrst_frame_done", o_frame_done, 0);
      i_rst = 1'b0;
      low_cnt = 0;
      done_cnt = 0;
      repeat (3000) begin
         @(negedge clk_sys);
         if (o_uart_tx !== 1'b1) low_cnt++;
         if (o_frame_done !== 1'b0) done_cnt++;
      end
      chk("no_tx_after_rst", low_cnt, 0);
      chk("no_done_after_rst", done_cnt, 0);

      // counters must be clean after the aborted capture
      send_capture(3, 8, 1'b1, 1'b0);
      rx_frame();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
